// File: rtl/rv_pkg.sv
// Shared RV32I datapath definitions: data/address widths, the x0 address
// and the common word/register-address types.
package rv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef logic [XLEN-1:0]   word_t;
   typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : rv_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port of the RV32I register file.
// Selects the addressed register, forces x0 to zero and, when the
// REGFILE_BYPASS_EN macro is defined, forwards same-cycle write data
// (write-first). Without the macro it returns stored state only.
module regfile_read_port
   import rv_pkg::*;
#(
   parameter int XLEN  = rv_pkg::XLEN,
   parameter int NREGS = 32,
   parameter int AW    = rv_pkg::REG_AW
) (
   input  logic [XLEN-1:0] regs_i [NREGS],
   input  logic [AW-1:0]   addr_i,
   input  logic            we_i,
   input  logic            reset_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata_o
);

   localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

`ifdef REGFILE_BYPASS_EN
   logic bypass_s;

   // A write that will actually land this edge on the same address wins.
   always_comb begin
      bypass_s = we_i && !reset_i && (waddr_i != ADDR_ZERO) && (waddr_i == addr_i);
   end
`else
   // Write-port signals only matter to the forwarding path.
   logic unused_wport_s;
   assign unused_wport_s = ^{we_i, reset_i, waddr_i, wdata_i};
`endif

   // Read mux: x0 is always zero, otherwise forwarded or stored data.
   always_comb begin
      rdata_o = {XLEN{1'b0}};
      if (addr_i == ADDR_ZERO) begin
         rdata_o = {XLEN{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (bypass_s) begin
         rdata_o = wdata_i;
`endif
      end else begin
         rdata_o = regs_i[addr_i];
      end
   end

endmodule : regfile_read_port

// File: rtl/rv32i_register_file.sv
// RV32I architectural register file: NREGS x XLEN, two combinational read
// ports and one clocked write port; x0 is hardwired to zero. Synchronous
// active-high reset clears every register and overrides a concurrent write.
// Optional feature: define REGFILE_BYPASS_EN for write-first read ports.
module rv32i_register_file
#(
   parameter int XLEN  = rv_pkg::XLEN,
   parameter int NREGS = 32,
   parameter int AW    = rv_pkg::REG_AW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we3,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   input  logic [AW-1:0]   a3,
   input  logic [XLEN-1:0] wd3,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   import rv_pkg::*;

   localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   // Next state: the addressed register takes wd3; x0 writes are dropped.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we3 && (a3 != ADDR_ZERO)) begin
         regs_d[a3] = wd3;
      end else begin
         regs_d[a3] = regs_q[a3];
      end
   end

   // Register storage; reset has priority over any pending write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (reset) begin
            regs_q[i] <= {XLEN{1'b0}};
         end else begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   regfile_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_read_port1 (
      .regs_i  (regs_q),
      .addr_i  (a1),
      .we_i    (we3),
      .reset_i (reset),
      .waddr_i (a3),
      .wdata_i (wd3),
      .rdata_o (rd1)
   );

   regfile_read_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_read_port2 (
      .regs_i  (regs_q),
      .addr_i  (a2),
      .we_i    (we3),
      .reset_i (reset),
      .waddr_i (a3),
      .wdata_i (wd3),
      .rdata_o (rd2)
   );

endmodule : rv32i_register_file

// File: tb/tb_rv32i_register_file.sv
// Self-checking bench for rv32i_register_file: a table of write/read
// vectors plus hand-written sequences for reset and same-cycle read/write.
// Expected values follow REGFILE_BYPASS_EN when it is defined.
module tb_rv32i_register_file;

   logic        clk;
   logic        reset;
   logic        we3;
   logic [4:0]  a1;
   logic [4:0]  a2;
   logic [4:0]  a3;
   logic [31:0] wd3;
   logic [31:0] rd1;
   logic [31:0] rd2;

   int checks_s;
   int errors_s;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [8];

   rv32i_register_file dut (
      .clk   (clk),
      .reset (reset),
      .we3   (we3),
      .a1    (a1),
      .a2    (a2),
      .a3    (a3),
      .wd3   (wd3),
      .rd1   (rd1),
      .rd2   (rd2)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_s++;
      if (act !== exp) begin
         errors_s++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i);
         a2 = 5'(31 - i);
         #1;
         check($sformatf("%s_rd1_x%0d", name, i), rd1, 32'h0000_0000);
         check($sformatf("%s_rd2_x%0d", name, 31 - i), rd2, 32'h0000_0000);
      end
   endtask

   initial begin
      checks_s = 0;
      errors_s = 0;

      //            rst   we    wa     wd             ra1    ra2    exp1           exp2
      vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hAAAA5555, 5'd5,  5'd0,  32'hAAAA5555, 32'h00000000};
      vecs[1] = '{1'b0, 1'b1, 5'd10, 32'h12345678, 5'd10, 5'd5,  32'h12345678, 32'hAAAA5555};
      vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
      vecs[3] = '{1'b0, 1'b0, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,  32'h00000000, 32'h00000000};
      vecs[4] = '{1'b0, 1'b1, 5'd31, 32'h80000001, 5'd31, 5'd10, 32'h80000001, 32'h12345678};
      vecs[5] = '{1'b0, 1'b1, 5'd1,  32'h00000001, 5'd1,  5'd1,  32'h00000001, 32'h00000001};
      vecs[6] = '{1'b0, 1'b1, 5'd5,  32'h0F0F0F0F, 5'd5,  5'd31, 32'h0F0F0F0F, 32'h80000001};
      vecs[7] = '{1'b1, 1'b1, 5'd5,  32'h00000001, 5'd5,  5'd10, 32'h00000000, 32'h00000000};

      reset = 1'b1;
      we3   = 1'b0;
      a1    = 5'd0;
      a2    = 5'd0;
      a3    = 5'd0;
      wd3   = 32'h0000_0000;
      tick();
      reset = 1'b0;
      check_all_zero("after_reset");

      for (int v = 0; v < 8; v++) begin
         reset = vecs[v].rst;
         we3   = vecs[v].we;
         a3    = vecs[v].wa;
         wd3   = vecs[v].wd;
         a1    = 5'd0;
         a2    = 5'd0;
         tick();
         reset = 1'b0;
         we3   = 1'b0;
         a1    = vecs[v].ra1;
         a2    = vecs[v].ra2;
         #1;
         check($sformatf("vec%0d_rd1", v), rd1, vecs[v].exp1);
         check($sformatf("vec%0d_rd2", v), rd2, vecs[v].exp2);
      end

      check_all_zero("after_reset_priority");

      // Same-cycle read and write of x3, sampled before the edge
      we3 = 1'b1;
      a3  = 5'd3;
      wd3 = 32'hCAFEF00D;
      a1  = 5'd3;
      a2  = 5'd4;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("samecycle_rd1_pre", rd1, 32'hCAFEF00D);
`else
      check("samecycle_rd1_pre", rd1, 32'h0000_0000);
`endif
      check("samecycle_rd2_other", rd2, 32'h0000_0000);
      tick();
      we3 = 1'b0;
      #1;
      check("samecycle_rd1_post", rd1, 32'hCAFEF00D);

      // Reset with a concurrent write: no forwarding, stored value until the edge
      reset = 1'b1;
      we3   = 1'b1;
      a3    = 5'd3;
      wd3   = 32'h0000_0001;
      a1    = 5'd3;
      a2    = 5'd3;
      #1;
      check("rst_write_rd1_pre", rd1, 32'hCAFEF00D);
      check("rst_write_rd2_pre", rd2, 32'hCAFEF00D);
      tick();
      reset = 1'b0;
      we3   = 1'b0;
      #1;
      check("rst_write_rd1_post", rd1, 32'h0000_0000);

      // Write disabled leaves the target unchanged
      we3 = 1'b1;
      a3  = 5'd12;
      wd3 = 32'h5A5A_A5A5;
      tick();
      we3 = 1'b0;
      wd3 = 32'hFFFF_FFFF;
      tick();
      a1 = 5'd12;
      #1;
      check("we_low_keeps_x12", rd1, 32'h5A5A_A5A5);

      $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
      $finish;
   end

endmodule : tb_rv32i_register_file
